mem_arbiter: RTL
================

# mem_arbiter

Shares one single-ported, variable-latency unified memory between the pipeline's instruction-fetch port and data-access port. Arbitrates between them with data priority and a one-shot fairness override, drives the memory handshake, and returns registered read data to the winning requester. It also aborts memory accesses that are never acknowledged. It sits between the CPU's two memory buses and the single memory model on the mother board; the pipeline holds its stalls until its port's `ready` pulses.

## Interface
- `AW`, 32, address width in bits
- `DW`, 32, data width in bits
- `TIMEOUT`, 255, maximum BUSY cycles without `m_ack` before abort (≥1)

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high
- `i_req`  in  1  instruction fetch request (read only)
- `i_addr`  in  AW  fetch address
- `i_ready`  out  1  one-cycle pulse: fetch complete
- `i_rdata`  out  DW  fetch data, valid while `i_ready`
- `d_req`  in  1  data request
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  AW  data address
- `d_wdata`  in  DW  store data
- `d_ready`  out  1  one-cycle pulse: data access complete
- `d_rdata`  out  DW  load data, valid while `d_ready`
- `err`  out  1  qualifies the `ready` pulse: access timed out
- `m_req`  out  1  memory request, held until `m_ack` or abort
- `m_we`  out  1  memory write enable
- `m_addr`  out  AW  memory address
- `m_wdata`  out  DW  memory write data
- `m_rdata`  in  DW  memory read data, valid with `m_ack`
- `m_ack`  in  1  single-cycle completion from memory

## Operation
- **Requester rules:**
  - A requester holds `req` and its address/data stable until it sees its `ready`.
  - It deasserts `req` or presents a new request in the following cycle.
- **FSM states:**
  - **IDLE**
    - No request: stay.
    - Only `d_req`: grant D.
    - Only `i_req`: grant I.
    - Both: grant D, unless `last_d`=1, in which case grant I.
    - On grant: latch owner, `m_we`, `m_addr` and `m_wdata` into registers; set `last_d` = (owner==D); go to BUSY.
  - **BUSY**
    - `m_req`=1 with the latched command.
    - On `m_ack`: capture `m_rdata` (captured even for stores), clear `err_r`, go to RESP.
    - If the timeout counter reaches `TIMEOUT` without `m_ack`: drop `m_req`, set `err_r`=1, set captured data to 0, go to RESP.
  - **RESP**
    - Pulse the owner's `ready` with the captured data; `err`=`err_r`.
    - Requests are ignored in this state.
    - Next state: IDLE.
- **Fairness:** `last_d` gives alternation when both ports are continuously requesting: D, I, D, I… A lone requester is never blocked by `last_d`.
- **Write path:**
  - `m_we` is 0 for I grants.
  - `m_wdata` is 0 for I grants and for D loads.
- **Outputs outside their state:**
  - `m_addr`, `m_we` and `m_wdata` hold their registered values outside BUSY.
  - `i_rdata` and `d_rdata` are driven from the shared capture register; they are meaningful only during the port's `ready`.
- **Timeout counter:**
  - Width is `$clog2(TIMEOUT+1)`.
  - Cleared on entry to BUSY; increments each BUSY cycle without `m_ack`; saturates, never wraps.
  - `m_ack` in the same cycle the count reaches `TIMEOUT` wins: normal completion, `err`=0.
- **Late ack:** an `m_ack` arriving outside BUSY is ignored. This covers late acks after an abort.

## Timing
- **Reset values:** all outputs 0, state IDLE, `last_d`=0, counter 0, capture register 0.
- **Reset mid-operation:** on the edge with `reset`=1 the FSM returns to IDLE and `m_req` is 0 from the next cycle. No `ready` is issued for the aborted access; the requester re-requests after reset.
- **Latency:**
  - Request sampled in IDLE at cycle n.
  - `m_req` is asserted in n+1.
  - With `m_ack` at cycle n+k (k≥1), `ready` is high at n+k+1.
  - Minimum request-to-ready latency is 2 cycles.
- **Back-to-back:** the minimum cycle time per access is 3 cycles (IDLE, BUSY, RESP).
- **`ready`:** exactly one cycle wide; registered, with no combinational path from `m_ack`.
- **`m_req`:** a pure function of state; it never toggles within a BUSY period.
- **Timeout:** with no ack, `m_req` is high for exactly `TIMEOUT` cycles; the `err` pulse follows one cycle later.

## Structure
- Add to `lib_cpu`:
  - `typedef enum logic[1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} ARB_STATE;`
  - `typedef enum logic {OWN_I, OWN_D} ARB_OWNER;`
- `AW`, `DW` and `TIMEOUT` stay module parameters. The package default for the timeout is `ARB_TIMEOUT_DEFAULT = 255`.
- Single module: one `always_ff` for state, command, capture register, counter and `last_d`; one `always_comb` for next-state and output decode. No sub-module.

## Test plan
- **Reset:** with `reset` held 3 cycles, assert `i_req`, `d_req` and `m_ack` → all outputs 0 throughout; IDLE afterwards.
- **Single fetch:** `i_req`, `i_addr`=0x0000_0040, memory acks 1 cycle after `m_req` with 0x2008_0005 → `m_addr`=0x40, `m_we`=0; `i_ready` pulse 2 cycles after `m_req` rise; `i_rdata`=0x2008_0005; `err`=0; `d_ready` never high.
- **Contention:** `i_req` and `d_req` both held continuously, each re-requesting after its `ready` → grant order D, I, D, I over 4 accesses. A store `d_addr`=0x54, `d_wdata`=0xDEAD_BEEF appears on `m_*` with `m_we`=1.
- **Timeout:** `TIMEOUT`=4, `d_req` load, `m_ack` never asserted → `m_req` high exactly 4 cycles, then `d_ready`=1, `err`=1, `d_rdata`=0. A late `m_ack` 2 cycles after that is ignored and the FSM stays in IDLE.
- **Ack at limit:** `TIMEOUT`=4, `m_ack` on the 4th BUSY cycle with 0x1234_5678 → `err`=0, `d_rdata`=0x1234_5678.
- **Reset mid-BUSY:** assert `reset` for 1 cycle in the 2nd BUSY cycle of a fetch → `m_req`=0 the next cycle, no `i_ready`. The fetch re-issued afterwards completes normally.

Source files
------------

// File: rtl/lib_cpu.sv
// lib_cpu: shared CPU-side types and defaults.
// Holds the memory arbiter FSM state and owner enums.
package lib_cpu;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_BUSY,
      ARB_RESP
   } ARB_STATE;

   typedef enum logic {
      OWN_I,
      OWN_D
   } ARB_OWNER;

   localparam int ARB_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one variable-latency memory between the fetch port
// and the data port, with data priority and one-shot fairness.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   i_req, i_addr          fetch request (read only)
//   i_ready, i_rdata       fetch completion pulse and data
//   d_req, d_we, d_addr,
//   d_wdata                data request (load/store)
//   d_ready, d_rdata       data completion pulse and load data
//   err                    qualifies a ready pulse: access timed out
//   m_req, m_we, m_addr,
//   m_wdata                memory command, held until ack or abort
//   m_rdata, m_ack         memory read data and completion pulse
module mem_arbiter
   import lib_cpu::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_ready,
   output logic [DW-1:0] i_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_ready,
   output logic [DW-1:0] d_rdata,
   output logic          err,
   output logic          m_req,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata,
   input  logic          m_ack
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   ARB_STATE      state;
   ARB_STATE      nxt;
   ARB_OWNER      owner;
   logic          we_r;
   logic [AW-1:0] addr_r;
   logic [DW-1:0] wdata_r;
   logic [DW-1:0] cap_r;
   logic          err_r;
   logic          last_d;
   logic [CW-1:0] cnt;

   logic          gnt_d;
   logic          gnt_i;
   logic          busy_to;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ARB_IDLE;
         owner   <= OWN_I;
         we_r    <= 1'b0;
         addr_r  <= '0;
         wdata_r <= '0;
         cap_r   <= '0;
         err_r   <= 1'b0;
         last_d  <= 1'b0;
         cnt     <= '0;
      end else begin
         state <= nxt;
         unique case (state)
            ARB_IDLE: begin
               if (gnt_d || gnt_i) begin
                  if (gnt_d) begin
                     owner  <= OWN_D;
                     addr_r <= d_addr;
                  end else begin
                     owner  <= OWN_I;
                     addr_r <= i_addr;
                  end
                  // Fetches never write; loads carry no write data.
                  we_r    <= gnt_d & d_we;
                  wdata_r <= (gnt_d && d_we) ? d_wdata : '0;
                  last_d  <= gnt_d;
                  cnt     <= '0;
               end
            end
            ARB_BUSY: begin
               // An ack on the final allowed cycle still completes normally.
               if (m_ack) begin
                  cap_r <= m_rdata;
                  err_r <= 1'b0;
               end else begin
                  if (busy_to) begin
                     cap_r <= '0;
                     err_r <= 1'b1;
                  end
                  if (cnt != CNT_MAX) begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      nxt     = state;
      gnt_d   = 1'b0;
      gnt_i   = 1'b0;
      busy_to = 1'b0;
      m_req   = 1'b0;
      i_ready = 1'b0;
      d_ready = 1'b0;
      err     = 1'b0;
      unique case (state)
         ARB_IDLE: begin
            // Data wins, except right after a data grant when fetch waits.
            gnt_d = d_req & (~i_req | ~last_d);
            gnt_i = i_req & ~gnt_d;
            if (gnt_d || gnt_i) begin
               nxt = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            m_req   = 1'b1;
            busy_to = (cnt == CNT_LAST);
            if (m_ack || busy_to) begin
               nxt = ARB_RESP;
            end
         end
         ARB_RESP: begin
            i_ready = (owner == OWN_I);
            d_ready = (owner == OWN_D);
            err     = err_r;
            nxt     = ARB_IDLE;
         end
         default: begin
            nxt = ARB_IDLE;
         end
      endcase
   end

   assign m_we    = we_r;
   assign m_addr  = addr_r;
   assign m_wdata = wdata_r;
   assign i_rdata = cap_r;
   assign d_rdata = cap_r;

endmodule
